fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin arbiter that shares the write port of one Async_FIFO instance among NUM_REQ requesters in the write-clock domain. Grants are bursts of up to MAX_BURST words, honour FIFO `full`, and rotate fairly. The block sits directly in front of the FIFO `write`/`wdata` inputs; the read side is untouched.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; matches the FIFO.
- NUM_REQ, 4, number of requesters; must be ≥2.
- MAX_BURST, 4, maximum words accepted per grant; must be ≥1.

Ports:
- wr_clk  in  1  FIFO write clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester "word available"; level, held until acked.
- req_data  in  NUM_REQ*DATA_WIDTH  flat packed; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_REQ  one-hot accept pulse; word taken this cycle.
- gnt  out  NUM_REQ  registered one-hot current owner; 0 when idle.
- full  in  1  FIFO full (write domain).
- write  out  1  FIFO write strobe.
- wdata  out  DATA_WIDTH  FIFO write data.
- busy  out  1  registered; 1 while in GRANT.

## Operation
- State machine: IDLE, GRANT. Registered state: `state`, `gnt`, `ptr` (clog2(NUM_REQ) bits, next-priority index), `bcnt` (clog2(MAX_BURST)+1 bits, accepted words in current burst).
- IDLE: when `|req` and `!full`, select the first asserted req searching ptr, ptr+1, … modulo NUM_REQ. Next cycle: gnt = onehot(winner), bcnt = 0, state = GRANT. With no req, or with full asserted, stay in IDLE.
- GRANT, owner k: combinational ack[k] = req[k] & !full & !rst; write = ack[k]; wdata = req_data[k]. No other ack bit is ever asserted.
- Each ack increments bcnt. Release when ack occurs with bcnt == MAX_BURST-1, or when req[k] == 0 (no write that cycle). On release: gnt = 0, ptr = (k+1) mod NUM_REQ, state = IDLE.
- full in GRANT: grant is held, no ack, bcnt frozen; no timeout.
- When write = 0, wdata = 0 (no stale data on the port).
- Fairness: a continuously requesting i waits at most (NUM_REQ-1) bursts plus stall time.

## Timing
- Reset values: state IDLE, gnt 0, busy 0, ptr 0, bcnt 0. ack, write and wdata are 0 while rst is high, including when rst asserts mid-burst. Partial bursts are dropped; already-written words stay in the FIFO.
- Grant latency: req rising in cycle n (IDLE, !full) gives gnt/busy in n+1 and the first ack/write in n+1.
- Throughput: MAX_BURST words per MAX_BURST+1 cycles; one IDLE cycle separates bursts, even for the same requester.
- ack/write/wdata are combinational from registered gnt and the inputs req, req_data, full. No path exists from req_data to ack.
- Requester rule: in the ack cycle the requester presents its next word (or drops req) at the following edge. The data sampled at the edge where ack = 1 is the word written.
- Full at the boundary: full rising in the same cycle as a would-be ack suppresses it; the word is retried later, never lost or duplicated.
- ptr wraps from NUM_REQ-1 to 0. bcnt never exceeds MAX_BURST-1 when registered.

## Test plan
- Single requester: req[0] held with data 17, 20, 800&0xFF, … (10 words), MAX_BURST=4, FIFO drained. Expect writes in bursts of 4, 4, 2, one idle cycle between bursts, and FIFO read order 17, 20, 0x20, …
- All four requesting continuously. Expect the grant order 0, 1, 2, 3, 0, … with 4 words each; no gnt ever multi-hot; ack == write per cycle.
- FIFO fill (depth 8) with no reads: requesters 0 and 1 push 10 words total. Expect exactly 8 writes, then full holds gnt with ack = 0. After 2 reads, exactly 2 more writes with no duplicate or lost word.
- Early release: req[2] drops after 2 words of a 4-word burst. Expect release the cycle after, ptr = 3, and the next grant to requester 3 if asserted.
- Reset mid-burst: assert rst for 1 cycle during the 2nd word of a burst. Expect write = 0 that cycle, then gnt = 0, busy = 0, ptr = 0; the following arbitration starts at requester 0.
- ptr wrap: the last burst goes to requester 3, then only req[0] and req[2] are asserted. Expect a grant to 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_wr_arbiter : round-robin burst arbiter for a FIFO write port     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          full,
  output logic                          write,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          busy
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int BCNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic                busy_q;

  logic [NUM_REQ-1:0]  win_oh_d;
  logic [PTR_W-1:0]    own_idx_d;
  logic [PTR_W-1:0]    ptr_rel_d;
  logic                release_d;

  // Rotating-priority search: first asserted request at ptr, ptr+1, ... (mod NUM_REQ).
  always_comb begin
    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    win_oh_d = '0;
    found    = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      cand = sum[PTR_W-1:0];
      if (!found && req[cand]) begin
        win_oh_d[cand] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  always_comb begin
    own_idx_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        own_idx_d = PTR_W'(i);
      end
    end
  end

  assign ptr_rel_d = (own_idx_d == PTR_LAST) ? '0 : own_idx_d + PTR_W'(1);

  // Only the owner can be acked; reset and full both block the write the same cycle.
  assign ack   = gnt_q & req & {NUM_REQ{~full & ~rst}};
  assign write = |ack;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) begin
        wdata = wdata | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Burst ends on the last allowed word or when the owner withdraws its request.
  assign release_d = !req[own_idx_d] || (write && (bcnt_q == BCNT_LAST));

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req && !full) begin
            state_q <= S_GRANT;
            gnt_q   <= win_oh_d;
            bcnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (release_d) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= ptr_rel_d;
            bcnt_q  <= '0;
            busy_q  <= 1'b0;
          end else if (write) begin
            bcnt_q  <= bcnt_q + BCNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule
`default_nettype wire
